// File: rtl/intctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_wb
//  Description : 32-bit Wishbone classic bundle used on the I/O bus.
//                slave  : adr, dat_i, we, sel, cyc, stb in; dat_o, ack out
//                master : the mirror image
//  Revision    : 1.0  initial release
// ============================================================================
interface if_wb;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport slave  (input adr, dat_i, we, sel, cyc, stb, output dat_o, ack);
    modport master (output adr, dat_i, we, sel, cyc, stb, input dat_o, ack);
endinterface
`default_nettype wire

// File: rtl/intctrl.sv
`default_nettype none
// ============================================================================
//  Module      : intctrl
//  Description : Interrupt controller for the bexkat2 CPU. Latches requests
//                from the MMU, timer and UART into a pending register, masks
//                them, and presents the lowest-index request as an encoded
//                vector with a hold-until-taken handshake.
//  Ports       : clk_i, rst_i     clock / synchronous active-high reset
//                bus              Wishbone slave (PENDING, MASK, VECTOR, FORCE)
//                mmu              source 0
//                timer_in[3:0]    sources 1-4
//                serial0_in[1:0]  sources 5-6
//                enabled          CPU interrupt-enable state
//                cpu_exception    0 = none, else source index + 1
//  Revision    : 1.0  initial release
// ============================================================================
module intctrl #(
    parameter logic [7:0] EDGE     = 8'h7F,
    parameter bit         FORCE_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        bus,
    input  logic       mmu,
    input  logic [3:0] timer_in,
    input  logic [1:0] serial0_in,
    input  logic       enabled,
    output logic [3:0] cpu_exception
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    localparam logic [1:0] C_REG_PENDING = 2'd0;
    localparam logic [1:0] C_REG_MASK    = 2'd1;
    localparam logic [1:0] C_REG_VECTOR  = 2'd2;
    localparam logic [1:0] C_REG_FORCE   = 2'd3;

    // Registered state
    state_t      state_q,   state_d;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  mask_q,    mask_d;
    logic [7:0]  prev_q,    prev_d;
    logic [2:0]  idx_q,     idx_d;
    logic [3:0]  exc_q,     exc_d;
    logic        ack_q,     ack_d;
    logic [31:0] dat_o_q,   dat_o_d;

    // Combinational helpers
    logic [7:0]  w_src;
    logic        w_acc;
    logic        w_wr;
    logic [1:0]  w_reg;
    logic [7:0]  w_req;
    logic        w_hit;
    logic [2:0]  w_idx;
    logic [7:0]  w_set;
    logic [7:0]  w_force;
    logic [7:0]  w_clr;
    logic        w_unused_bits;

    // Address/data bits that do not decode to anything.
    assign w_unused_bits = ^{bus.adr[31:4], bus.adr[1:0], bus.sel[3:1], bus.dat_i[31:8]};

    always_comb begin
        w_src = {1'b0, serial0_in, timer_in, mmu};
        prev_d = w_src;

        // A new access is the one cycle in which ack is about to rise; all
        // register side effects and read data capture happen then.
        w_acc = bus.cyc & bus.stb & ~ack_q;
        w_wr  = w_acc & bus.we & bus.sel[0];
        w_reg = bus.adr[3:2];
        ack_d = w_acc;

        // Lowest set request index wins.
        w_req = pending_q & mask_q;
        w_hit = 1'b0;
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_req[i]) begin
                w_hit = 1'b1;
                w_idx = i[2:0];
            end
        end

        // Per-source sense: edge bits fire once per rising edge, level bits
        // re-assert every cycle the input is high (so clears cannot stick).
        w_set   = (w_src & ~prev_q & EDGE) | (w_src & ~EDGE);
        w_force = (w_wr && (w_reg == C_REG_FORCE) && FORCE_EN) ? bus.dat_i[7:0] : 8'h00;
        w_clr   = (w_wr && (w_reg == C_REG_PENDING)) ? bus.dat_i[7:0] : 8'h00;
        if ((state_q == ST_PRESENT) && !enabled) begin
            w_clr = w_clr | (8'h01 << idx_q);
        end

        // Sets are applied after clears so a same-cycle set wins.
        // Source 7 has no input and is never allowed to pend.
        pending_d = ((pending_q & ~w_clr) | w_set | w_force) & 8'h7F;

        mask_d = (w_wr && (w_reg == C_REG_MASK)) ? bus.dat_i[7:0] : mask_q;

        dat_o_d = dat_o_q;
        if (w_acc) begin
            case (w_reg)
                C_REG_PENDING: dat_o_d = {24'd0, pending_q};
                C_REG_MASK:    dat_o_d = {24'd0, mask_q};
                C_REG_VECTOR:  dat_o_d = {28'd0, exc_q};
                default:       dat_o_d = 32'd0;
            endcase
        end

        // CPU handshake
        state_d = state_q;
        idx_d   = idx_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                exc_d = 4'd0;
                if (enabled && w_hit) begin
                    idx_d   = w_idx;
                    exc_d   = {1'b0, w_idx} + 4'd1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Vector is frozen until the CPU drops enabled to take it.
                if (!enabled) begin
                    exc_d   = 4'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                exc_d = 4'd0;
                if (enabled) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                exc_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 8'h00;
            mask_q    <= 8'h00;
            prev_q    <= 8'h00;
            idx_q     <= 3'd0;
            exc_q     <= 4'd0;
            ack_q     <= 1'b0;
            dat_o_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            prev_q    <= prev_d;
            idx_q     <= idx_d;
            exc_q     <= exc_d;
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.dat_o     = dat_o_q;
    assign cpu_exception = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_intctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intctrl
//  Description : Scoreboard bench for intctrl. Stimulus pushes expected read
//                data and expected cpu_exception transitions into queues; a
//                monitor pops and compares when the DUT acks a read or its
//                vector output changes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_intctrl;

    localparam logic [3:0] A_PEND  = 4'h0;
    localparam logic [3:0] A_MASK  = 4'h4;
    localparam logic [3:0] A_VEC   = 4'h8;
    localparam logic [3:0] A_FORCE = 4'hC;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       mmu;
    logic [3:0] timer_in;
    logic [1:0] serial0_in;
    logic       enabled;
    logic [3:0] cpu_exception;

    if_wb bus ();

    intctrl #(.EDGE(8'h7F), .FORCE_EN(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .bus          (bus),
        .mmu          (mmu),
        .timer_in     (timer_in),
        .serial0_in   (serial0_in),
        .enabled      (enabled),
        .cpu_exception(cpu_exception)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [3:0] val;
        int         cyc;   // -1: any cycle
    } exc_t;

    exc_t        exc_sb[$];
    logic [31:0] rd_sb[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    logic [3:0]  last_exc = 4'd0;
    exc_t        m_e;
    logic [31:0] m_d;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ack === 1'b1 && bus.we === 1'b0) begin
                total++;
                if (rd_sb.size() == 0) begin
                    bad++;
                    $display("FAIL rd_data: unexpected read ack, dat_o=%08h", bus.dat_o);
                end else begin
                    m_d = rd_sb.pop_front();
                    if (bus.dat_o !== m_d) begin
                        bad++;
                        $display("FAIL rd_data: dat_o=%08h required=%08h", bus.dat_o, m_d);
                    end
                end
            end
            if (cpu_exception !== last_exc) begin
                total++;
                if (exc_sb.size() == 0) begin
                    bad++;
                    $display("FAIL exc_change: unexpected cpu_exception=%h at cycle %0d", cpu_exception, cyc_cnt);
                end else begin
                    m_e = exc_sb.pop_front();
                    if (cpu_exception !== m_e.val || (m_e.cyc >= 0 && cyc_cnt != m_e.cyc)) begin
                        bad++;
                        $display("FAIL exc_change: cpu_exception=%h at cycle %0d, required %h at cycle %0d",
                                 cpu_exception, cyc_cnt, m_e.val, m_e.cyc);
                    end
                end
                last_exc = cpu_exception;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wb_access(input bit we, input logic [3:0] adr, input logic [31:0] wdata,
                             output int ack_cyc);
        int n;
        @(negedge clk); #1;
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = {28'd0, adr};
        bus.dat_i = wdata;
        bus.sel   = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack !== 1'b1 && n < 8);
        total++;
        if (bus.ack !== 1'b1 || n != 1) begin
            bad++;
            $display("FAIL wb_wait: ack after %0d cycles (ack=%b), required 1", n, bus.ack);
        end
        ack_cyc = cyc_cnt;
        #1;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] expv);
        int c;
        rd_sb.push_back(expv);
        wb_access(1'b0, adr, 32'd0, c);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] d, output int ack_cyc);
        wb_access(1'b1, adr, d, ack_cyc);
    endtask

    task automatic expect_exc(input logic [3:0] v, input int c);
        exc_t e;
        e.val = v;
        e.cyc = c;
        exc_sb.push_back(e);
    endtask

    task automatic pulse(input logic m, input logic [3:0] t, input logic [1:0] s);
        @(negedge clk); #1;
        mmu = m; timer_in = t; serial0_in = s;
        @(negedge clk); #1;
        mmu = 1'b0; timer_in = 4'd0; serial0_in = 2'd0;
    endtask

    task automatic set_en(input logic v);
        @(negedge clk); #1;
        enabled = v;
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    int ac;
    int ac2;

    initial begin
        rst_i = 1'b1; mmu = 1'b0; timer_in = 4'd0; serial0_in = 2'd0; enabled = 1'b0;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = 32'd0;
        bus.dat_i = 32'd0; bus.sel = 4'h0;
        repeat (3) @(negedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_exception !== 4'd0 || bus.ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cpu_exception=%h ack=%b, required 0/0", cpu_exception, bus.ack);
        end
        mon_en = 1'b1;
        rd(A_PEND, 32'h0);
        rd(A_MASK, 32'h0);
        rd(A_VEC,  32'h0);

        // Masked timer pulse only pends.
        pulse(1'b0, 4'b0001, 2'b00);
        waitc(1);
        rd(A_PEND, 32'h02);

        // Unmask: vector one cycle after write ack, then take and release.
        set_en(1'b1);
        wr(A_MASK, 32'hFF, ac);
        expect_exc(4'h2, ac + 1);
        waitc(2);
        expect_exc(4'h0, -1);
        set_en(1'b0);
        waitc(2);
        rd(A_PEND, 32'h00);
        set_en(1'b1);
        waitc(2);

        // Simultaneous mmu + serial0_in[1]: lowest index first.
        expect_exc(4'h1, -1);
        pulse(1'b1, 4'b0000, 2'b10);
        waitc(2);
        expect_exc(4'h0, -1);
        set_en(1'b0);
        waitc(2);
        rd(A_PEND, 32'h40);
        expect_exc(4'h7, -1);
        set_en(1'b1);
        waitc(3);
        expect_exc(4'h0, -1);
        set_en(1'b0);
        waitc(2);
        set_en(1'b1);
        waitc(2);

        // Presented vector holds through a mask change.
        expect_exc(4'h3, -1);
        pulse(1'b0, 4'b0010, 2'b00);
        waitc(2);
        wr(A_MASK, 32'h00, ac);
        waitc(3);
        expect_exc(4'h0, -1);
        set_en(1'b0);
        waitc(2);
        set_en(1'b1);
        waitc(2);

        // Register access with enabled low; set beats W1C.
        set_en(1'b0);
        pulse(1'b0, 4'b0000, 2'b01);
        waitc(1);
        fork
            wr(A_PEND, 32'h20, ac2);
            begin
                @(negedge clk); #1;
                serial0_in = 2'b01;
                @(negedge clk); #1;
                serial0_in = 2'b00;
            end
        join
        rd(A_PEND, 32'h20);
        wr(A_PEND, 32'h20, ac);
        rd(A_PEND, 32'h00);
        wr(A_FORCE, 32'h10, ac);
        rd(A_FORCE, 32'h00);
        rd(A_PEND, 32'h10);
        wr(A_MASK, 32'hABCD_EF5A, ac);
        rd(A_MASK, 32'h5A);
        waitc(2);
        wr(A_PEND, 32'h10, ac);

        // Mask selects a higher index over a lower pending one.
        wr(A_MASK, 32'h08, ac);
        set_en(1'b1);
        wr(A_FORCE, 32'h0C, ac);
        expect_exc(4'h4, ac + 1);
        waitc(2);
        expect_exc(4'h0, -1);
        set_en(1'b0);
        waitc(2);
        set_en(1'b1);
        waitc(1);
        rd(A_PEND, 32'h04);
        wr(A_PEND, 32'h04, ac);
        rd(A_PEND, 32'h00);
        wr(A_MASK, 32'hFF, ac);

        // VECTOR read while presenting 5.
        expect_exc(4'h5, -1);
        pulse(1'b0, 4'b1000, 2'b00);
        waitc(2);
        rd(A_VEC, 32'h5);

        // Reset while presenting.
        @(negedge clk); #1;
        expect_exc(4'h0, cyc_cnt + 1);
        rst_i = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack: ack=%b, required 0", bus.ack);
        end
        #1 rst_i = 1'b0;
        rd(A_PEND, 32'h00);
        rd(A_MASK, 32'h00);
        waitc(3);

        total++;
        if (exc_sb.size() != 0 || rd_sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: exc left=%0d rd left=%0d, required 0/0",
                     exc_sb.size(), rd_sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
